execute_hazard_control: RTL and testbench
=========================================

Name: execute_hazard_control

Overview:
- Pipeline sequencer for the execute/address-calculate stage.
- Detects load-use hazards, applies branch/jump redirect flushes and sequences multi-cycle ALU operations (mul/div) with a bounded busy counter.
- Drives stall/flush/bubble controls to the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sits beside the execute stage; takes decode-stage operand addresses and execute-stage status.

Parameters:
REG_ADDR_WIDTH, 5, register file address width
MC_CNT_WIDTH, 6, width of multi-cycle busy counter
MC_MAX_CYCLES, 34, timeout bound for a multi-cycle op (must be < 2^MC_CNT_WIDTH)
STALL_CNT_WIDTH, 16, width of stall performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
flush_in  input  1  external abort (exception/interrupt), highest priority
id_reg_a_addr_in  input  REG_ADDR_WIDTH  decode-stage source A address
id_reg_b_addr_in  input  REG_ADDR_WIDTH  decode-stage source B address
id_reg_a_used_in  input  1  decode instruction reads A
id_reg_b_used_in  input  1  decode instruction reads B
ex_mem_data_rd_en_in  input  1  instruction in EX is a load
ex_reg_wr_en_in  input  1  instruction in EX writes a register
ex_reg_wr_addr_in  input  REG_ADDR_WIDTH  EX destination address
ex_select_new_pc_in  input  1  EX branch taken / jump (from branch control)
ex_mc_start_in  input  1  EX instruction is multi-cycle (one-cycle pulse on entry)
ex_mc_done_in  input  1  multi-cycle unit result valid
fetch_stall_out  output  1  hold PC and IF/ID
decode_stall_out  output  1  hold ID/EX
decode_flush_out  output  1  clear IF/ID to NOP
execute_flush_out  output  1  load NOP into ID/EX
memory_bubble_out  output  1  load NOP into EX/MEM
mc_busy_out  output  1  multi-cycle sequence in progress
mc_timeout_out  output  1  sticky: an op hit MC_MAX_CYCLES without done
stall_count_out  output  STALL_CNT_WIDTH  saturating count of cycles with fetch_stall_out=1

Behaviour:
- States: RUN, MC_BUSY. Reset -> RUN, counter 0, mc_timeout_out 0, stall_count_out 0; all control outputs 0 during reset.
- Control outputs are combinational from state and inputs (same-cycle effect); counters and sticky flag are registered.
- load_use = ex_mem_data_rd_en_in & ex_reg_wr_en_in & (ex_reg_wr_addr_in != 0) & ((id_reg_a_used_in & addr A match) | (id_reg_b_used_in & addr B match)).
- RUN priority, highest first:
  - flush_in: decode_flush, execute_flush, memory_bubble = 1; stay RUN.
  - ex_select_new_pc_in: decode_flush = 1, execute_flush = 1; no stall; load_use and ex_mc_start_in ignored (the younger instruction is squashed).
  - ex_mc_start_in: fetch_stall, decode_stall, memory_bubble = 1; counter <= MC_MAX_CYCLES-1; -> MC_BUSY. If ex_mc_done_in is also 1, this is a single-cycle completion: no stall, stay RUN.
  - load_use: fetch_stall = 1, decode_stall = 1, execute_flush = 1 for exactly one cycle. Next cycle the load is in MEM, so the condition clears naturally.
- MC_BUSY:
  - fetch_stall, decode_stall, memory_bubble, mc_busy = 1; counter decrements each cycle.
  - ex_mc_done_in = 1: outputs in this cycle are fetch_stall = 0, decode_stall = 0, memory_bubble = 0 (result passes to EX/MEM); -> RUN.
  - counter == 0 without done: same release as done; mc_timeout_out <= 1; -> RUN.
  - flush_in: flush behaviour as in RUN, stalls deasserted; -> RUN; counter cleared; no timeout set.
  - ex_select_new_pc_in and load_use are ignored in MC_BUSY.
- stall_count_out increments when fetch_stall_out = 1 and holds at all-ones.
- rst_n low mid-sequence: immediate return to RUN, all cleared.

Decomposition:
- Shared pipeline package holds the state encoding (RUN/MC_BUSY), REG_ADDR_WIDTH default and the zero-register constant.
- One natural sub-module: hazard_load_use_detect (pure compare logic).
- FSM, counter and performance counter stay in the top module.

Test Plan:
- Load r3 in EX, decode reads r3 on A -> one cycle of fetch_stall = decode_stall = execute_flush = 1; all 0 the next cycle. With ex_reg_wr_addr_in = 0: no stall.
- ex_select_new_pc_in = 1 together with load_use -> decode_flush = execute_flush = 1, fetch_stall = 0, stall_count_out unchanged.
- ex_mc_start_in pulse, ex_mc_done_in after 5 cycles -> stalls and mc_busy high for 5 cycles, low in the done cycle; stall_count_out advances by 5.
- ex_mc_start_in, never done, MC_MAX_CYCLES = 34 -> release after 34 stall cycles; mc_timeout_out = 1 and stays 1 until reset.
- flush_in on the 3rd cycle of MC_BUSY -> decode_flush, execute_flush, memory_bubble = 1 that cycle; state RUN; mc_timeout_out stays 0.
- Force 2^16+3 stall cycles (repeated ops) -> stall_count_out = 16'hFFFF. rst_n low mid-MC_BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/execute_hazard_control_pkg.sv
// Shared definitions for the execute-stage hazard sequencer: FSM state
// encoding, default register address width and the hard-wired zero register.
package execute_hazard_control_pkg;

  typedef enum logic {
    HC_RUN     = 1'b0,
    HC_MC_BUSY = 1'b1
  } hc_state_e;

  localparam int unsigned HC_REG_ADDR_WIDTH = 5;

  // Register 0 is hard-wired to zero; a write to it never creates a hazard.
  localparam int unsigned HC_ZERO_REG = 0;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use hazard detector: flags when the instruction in decode reads the
// destination of a load that is still in execute (data not yet available).
module hazard_load_use_detect
  import execute_hazard_control_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = HC_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr,
  input  logic                      id_reg_a_used,
  input  logic                      id_reg_b_used,
  input  logic                      ex_mem_data_rd_en,
  input  logic                      ex_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
  output logic                      load_use
);

  logic dest_live;
  logic a_hit;
  logic b_hit;

  // A load only matters if it actually writes a real (non-zero) register.
  assign dest_live = ex_mem_data_rd_en & ex_reg_wr_en &
                     (ex_reg_wr_addr != REG_ADDR_WIDTH'(HC_ZERO_REG));

  assign a_hit = id_reg_a_used & (id_reg_a_addr == ex_reg_wr_addr);
  assign b_hit = id_reg_b_used & (id_reg_b_addr == ex_reg_wr_addr);

  assign load_use = dest_live & (a_hit | b_hit);

endmodule

// File: rtl/execute_hazard_control.sv
// Execute-stage pipeline sequencer. Resolves load-use stalls, branch/jump
// redirect flushes and multi-cycle (mul/div) operation sequencing, and drives
// the stall/flush/bubble controls of the IF/ID, ID/EX and EX/MEM registers.
//
// Signalling: there is no valid/ready handshake here. Every control output is
// a level that is meaningful in every cycle and acts on the pipeline registers
// at the next rising edge; it is derived combinationally from the current
// state and this cycle's inputs, and forced low while rst_n is low.
module execute_hazard_control
  import execute_hazard_control_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH  = HC_REG_ADDR_WIDTH,
  parameter int unsigned MC_CNT_WIDTH    = 6,
  parameter int unsigned MC_MAX_CYCLES   = 34,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_in,
  input  logic [REG_ADDR_WIDTH-1:0]  id_reg_a_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0]  id_reg_b_addr_in,
  input  logic                       id_reg_a_used_in,
  input  logic                       id_reg_b_used_in,
  input  logic                       ex_mem_data_rd_en_in,
  input  logic                       ex_reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_reg_wr_addr_in,
  input  logic                       ex_select_new_pc_in,
  input  logic                       ex_mc_start_in,
  input  logic                       ex_mc_done_in,
  output logic                       fetch_stall_out,
  output logic                       decode_stall_out,
  output logic                       decode_flush_out,
  output logic                       execute_flush_out,
  output logic                       memory_bubble_out,
  output logic                       mc_busy_out,
  output logic                       mc_timeout_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_out,
  output hc_state_e                  state_dbg_out
);

  localparam logic [MC_CNT_WIDTH-1:0] MC_LOAD = MC_CNT_WIDTH'(MC_MAX_CYCLES - 1);

  hc_state_e                  state;
  logic [MC_CNT_WIDTH-1:0]    mc_cnt;
  logic                       mc_timeout;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  logic load_use;

  // Raw (pre-reset-gating) control decisions and FSM events.
  logic c_fetch_stall;
  logic c_decode_stall;
  logic c_decode_flush;
  logic c_execute_flush;
  logic c_memory_bubble;
  logic c_mc_busy;
  logic go_busy;
  logic leave_busy;
  logic timeout_hit;

  hazard_load_use_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_load_use (
    .id_reg_a_addr     (id_reg_a_addr_in),
    .id_reg_b_addr     (id_reg_b_addr_in),
    .id_reg_a_used     (id_reg_a_used_in),
    .id_reg_b_used     (id_reg_b_used_in),
    .ex_mem_data_rd_en (ex_mem_data_rd_en_in),
    .ex_reg_wr_en      (ex_reg_wr_en_in),
    .ex_reg_wr_addr    (ex_reg_wr_addr_in),
    .load_use          (load_use)
  );

  // Same-cycle control decode: priority abort > redirect > multi-cycle > load-use.
  always_comb begin
    c_fetch_stall   = 1'b0;
    c_decode_stall  = 1'b0;
    c_decode_flush  = 1'b0;
    c_execute_flush = 1'b0;
    c_memory_bubble = 1'b0;
    c_mc_busy       = 1'b0;
    go_busy         = 1'b0;
    leave_busy      = 1'b0;
    timeout_hit     = 1'b0;
    case (state)
      HC_RUN: begin
        if (flush_in) begin
          c_decode_flush  = 1'b1;
          c_execute_flush = 1'b1;
          c_memory_bubble = 1'b1;
        end else if (ex_select_new_pc_in) begin
          // The younger instruction in decode is squashed, so its hazards vanish.
          c_decode_flush  = 1'b1;
          c_execute_flush = 1'b1;
        end else if (ex_mc_start_in) begin
          // A result ready on entry completes in one cycle with no stall.
          if (!ex_mc_done_in) begin
            c_fetch_stall   = 1'b1;
            c_decode_stall  = 1'b1;
            c_memory_bubble = 1'b1;
            c_mc_busy       = 1'b1;
            go_busy         = 1'b1;
          end
        end else if (load_use) begin
          // One bubble suffices: next cycle the load is in MEM and can forward.
          c_fetch_stall   = 1'b1;
          c_decode_stall  = 1'b1;
          c_execute_flush = 1'b1;
        end
      end
      HC_MC_BUSY: begin
        if (flush_in) begin
          c_decode_flush  = 1'b1;
          c_execute_flush = 1'b1;
          c_memory_bubble = 1'b1;
          leave_busy      = 1'b1;
        end else if (ex_mc_done_in) begin
          // Result passes to EX/MEM this cycle, so stalls and bubble drop.
          leave_busy      = 1'b1;
        end else if (mc_cnt == '0) begin
          leave_busy      = 1'b1;
          timeout_hit     = 1'b1;
        end else begin
          c_fetch_stall   = 1'b1;
          c_decode_stall  = 1'b1;
          c_memory_bubble = 1'b1;
          c_mc_busy       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM, multi-cycle busy counter, sticky timeout flag and stall performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HC_RUN;
      mc_cnt     <= '0;
      mc_timeout <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        HC_RUN: begin
          if (go_busy) begin
            state  <= HC_MC_BUSY;
            mc_cnt <= MC_LOAD;
          end
        end
        HC_MC_BUSY: begin
          if (leave_busy) begin
            state  <= HC_RUN;
            mc_cnt <= '0;
          end else begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        default: begin
          state  <= HC_RUN;
          mc_cnt <= '0;
        end
      endcase
      if (timeout_hit) begin
        mc_timeout <= 1'b1;
      end
      if (c_fetch_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign fetch_stall_out   = rst_n & c_fetch_stall;
  assign decode_stall_out  = rst_n & c_decode_stall;
  assign decode_flush_out  = rst_n & c_decode_flush;
  assign execute_flush_out = rst_n & c_execute_flush;
  assign memory_bubble_out = rst_n & c_memory_bubble;
  assign mc_busy_out       = rst_n & c_mc_busy;
  assign mc_timeout_out    = mc_timeout;
  assign stall_count_out   = stall_cnt;
  assign state_dbg_out     = state;

endmodule

// File: tb/tb_execute_hazard_control.sv
// Directed bench for execute_hazard_control. The driver applies one cycle of
// inputs just after each rising edge and, for checked cycles, pushes the
// hand-computed expected output word; the monitor samples on the falling edge.
module tb_execute_hazard_control;
  import execute_hazard_control_pkg::*;

  localparam int W = 24;  // {fs,ds,df,ef,mb,busy,timeout, state_busy, stall_count[15:0]}

  logic        clk;
  logic        rst_n;
  logic        flush_in;
  logic [4:0]  id_reg_a_addr_in;
  logic [4:0]  id_reg_b_addr_in;
  logic        id_reg_a_used_in;
  logic        id_reg_b_used_in;
  logic        ex_mem_data_rd_en_in;
  logic        ex_reg_wr_en_in;
  logic [4:0]  ex_reg_wr_addr_in;
  logic        ex_select_new_pc_in;
  logic        ex_mc_start_in;
  logic        ex_mc_done_in;
  logic        fetch_stall_out;
  logic        decode_stall_out;
  logic        decode_flush_out;
  logic        execute_flush_out;
  logic        memory_bubble_out;
  logic        mc_busy_out;
  logic        mc_timeout_out;
  logic [15:0] stall_count_out;
  hc_state_e   state_dbg_out;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           passed = 0;
  int           total  = 0;

  execute_hazard_control #(
    .REG_ADDR_WIDTH  (5),
    .MC_CNT_WIDTH    (6),
    .MC_MAX_CYCLES   (34),
    .STALL_CNT_WIDTH (16)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_in             (flush_in),
    .id_reg_a_addr_in     (id_reg_a_addr_in),
    .id_reg_b_addr_in     (id_reg_b_addr_in),
    .id_reg_a_used_in     (id_reg_a_used_in),
    .id_reg_b_used_in     (id_reg_b_used_in),
    .ex_mem_data_rd_en_in (ex_mem_data_rd_en_in),
    .ex_reg_wr_en_in      (ex_reg_wr_en_in),
    .ex_reg_wr_addr_in    (ex_reg_wr_addr_in),
    .ex_select_new_pc_in  (ex_select_new_pc_in),
    .ex_mc_start_in       (ex_mc_start_in),
    .ex_mc_done_in        (ex_mc_done_in),
    .fetch_stall_out      (fetch_stall_out),
    .decode_stall_out     (decode_stall_out),
    .decode_flush_out     (decode_flush_out),
    .execute_flush_out    (execute_flush_out),
    .memory_bubble_out    (memory_bubble_out),
    .mc_busy_out          (mc_busy_out),
    .mc_timeout_out       (mc_timeout_out),
    .stall_count_out      (stall_count_out),
    .state_dbg_out        (state_dbg_out)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [6:0] ctrl, input logic busy_st,
                                      input logic [15:0] cnt);
    return {ctrl, busy_st, cnt};
  endfunction

  // Driver tasks
  task automatic idle();
    flush_in             = 1'b0;
    id_reg_a_addr_in     = '0;
    id_reg_b_addr_in     = '0;
    id_reg_a_used_in     = 1'b0;
    id_reg_b_used_in     = 1'b0;
    ex_mem_data_rd_en_in = 1'b0;
    ex_reg_wr_en_in      = 1'b0;
    ex_reg_wr_addr_in    = '0;
    ex_select_new_pc_in  = 1'b0;
    ex_mc_start_in       = 1'b0;
    ex_mc_done_in        = 1'b0;
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic [4:0] addr);
    ex_mem_data_rd_en_in = rd;
    ex_reg_wr_en_in      = wr;
    ex_reg_wr_addr_in    = addr;
  endtask

  task automatic set_id(input logic [4:0] a, input logic au, input logic [4:0] b, input logic bu);
    id_reg_a_addr_in = a;
    id_reg_a_used_in = au;
    id_reg_b_addr_in = b;
    id_reg_b_used_in = bu;
  endtask

  // Inputs for this cycle are already set; queue the expectation, then advance.
  task automatic apply(input string nm, input bit chk, input logic [W-1:0] exp);
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] obs;
      string        n;
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      obs = {fetch_stall_out, decode_stall_out, decode_flush_out, execute_flush_out,
             memory_bubble_out, mc_busy_out, mc_timeout_out,
             (state_dbg_out == HC_MC_BUSY), stall_count_out};
      total++;
      if (obs === e) passed++;
      else $display("FAIL %s: got %h expected %h", n, obs, e);
    end
  end

  // Directed stimulus
  initial begin
    idle();
    rst_n = 1'b0;
    flush_in = 1'b1;
    ex_mc_start_in = 1'b1;
    set_ex(1, 1, 5'd3);
    set_id(5'd3, 1, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    apply("reset_ctrl_low", 1, mk(7'b0000000, 0, 16'd0));

    rst_n = 1'b1;
    idle();
    // Load-use on A, then on B, plus the non-hazard boundary cases
    set_ex(1, 1, 5'd3); set_id(5'd3, 1, 5'd9, 1);
    apply("lu_a_stall", 1, mk(7'b1101000, 0, 16'd0));
    set_ex(0, 0, 5'd0);
    apply("lu_a_release", 1, mk(7'b0000000, 0, 16'd1));
    set_ex(1, 1, 5'd7); set_id(5'd3, 1, 5'd7, 1);
    apply("lu_b_stall", 1, mk(7'b1101000, 0, 16'd1));
    set_ex(1, 1, 5'd0); set_id(5'd0, 1, 5'd0, 1);
    apply("lu_zero_dest", 1, mk(7'b0000000, 0, 16'd2));
    set_ex(1, 1, 5'd5); set_id(5'd5, 0, 5'd6, 1);
    apply("lu_unused_src", 1, mk(7'b0000000, 0, 16'd2));
    set_ex(0, 1, 5'd5); set_id(5'd5, 1, 5'd5, 1);
    apply("lu_not_load", 1, mk(7'b0000000, 0, 16'd2));

    // Redirect beats load-use and mc start
    set_ex(1, 1, 5'd5); ex_select_new_pc_in = 1'b1; ex_mc_start_in = 1'b1;
    apply("br_over_lu", 1, mk(7'b0011000, 0, 16'd2));
    idle();
    apply("br_no_stall_cnt", 1, mk(7'b0000000, 0, 16'd2));

    // External abort beats everything
    set_ex(1, 1, 5'd5); set_id(5'd5, 1, 5'd0, 0);
    ex_select_new_pc_in = 1'b1; ex_mc_start_in = 1'b1; flush_in = 1'b1;
    apply("flush_top", 1, mk(7'b0011100, 0, 16'd2));

    // Single-cycle multi-cycle completion
    idle(); ex_mc_start_in = 1'b1; ex_mc_done_in = 1'b1;
    apply("mc_single", 1, mk(7'b0000000, 0, 16'd2));
    idle();
    apply("mc_single_run", 1, mk(7'b0000000, 0, 16'd2));

    // Multi-cycle op, done arrives 5 cycles after start
    ex_mc_start_in = 1'b1;
    apply("mc5_start", 1, mk(7'b1100110, 0, 16'd2));
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 1) begin
        set_ex(1, 1, 5'd4); set_id(5'd4, 1, 5'd0, 0); ex_select_new_pc_in = 1'b1;
      end
      apply("mc5_busy", 1, mk(7'b1100110, 1, 16'(3 + i)));
    end
    idle(); ex_mc_done_in = 1'b1;
    apply("mc5_done", 1, mk(7'b0000000, 1, 16'd7));
    idle();
    apply("mc5_back_run", 1, mk(7'b0000000, 0, 16'd7));

    // Abort on the 3rd busy cycle
    ex_mc_start_in = 1'b1;
    apply("fl_start", 1, mk(7'b1100110, 0, 16'd7));
    idle();
    apply("fl_busy1", 1, mk(7'b1100110, 1, 16'd8));
    apply("fl_busy2", 1, mk(7'b1100110, 1, 16'd9));
    flush_in = 1'b1;
    apply("fl_flush", 1, mk(7'b0011100, 1, 16'd10));
    idle();
    apply("fl_run_no_to", 1, mk(7'b0000000, 0, 16'd10));

    // Timeout: 34 stall cycles then release, sticky flag
    ex_mc_start_in = 1'b1;
    apply("to_start", 1, mk(7'b1100110, 0, 16'd10));
    idle();
    for (int i = 0; i < 33; i++) begin
      apply("to_busy", 1, mk(7'b1100110, 1, 16'(11 + i)));
    end
    apply("to_release", 1, mk(7'b0000000, 1, 16'd44));
    apply("to_sticky", 1, mk(7'b0000001, 0, 16'd44));

    // Reset in the middle of a busy sequence
    ex_mc_start_in = 1'b1;
    apply("rst_mc_start", 1, mk(7'b1100111, 0, 16'd44));
    idle();
    apply("rst_mc_busy", 1, mk(7'b1100111, 1, 16'd45));
    rst_n = 1'b0;
    apply("rst_mid_busy", 1, mk(7'b0000000, 0, 16'd0));
    rst_n = 1'b1;
    apply("rst_after", 1, mk(7'b0000000, 0, 16'd0));

    // Saturation: 2^16+3 consecutive load-use stall cycles
    set_ex(1, 1, 5'd12); set_id(5'd12, 1, 5'd0, 0);
    for (int i = 0; i < 65539; i++) begin
      if (i == 65534)      apply("sat_fffe", 1, mk(7'b1101000, 0, 16'hFFFE));
      else if (i == 65535) apply("sat_ffff", 1, mk(7'b1101000, 0, 16'hFFFF));
      else if (i == 65538) apply("sat_hold", 1, mk(7'b1101000, 0, 16'hFFFF));
      else                 apply("", 0, '0);
    end
    idle();
    apply("sat_idle", 1, mk(7'b0000000, 0, 16'hFFFF));

    // Final report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
